uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart to the board's existing fixed-message UART transmitter.
- Samples the asynchronous uart_in line and recovers bytes at 115200 baud from a 25 MHz clock.
- Hands each byte to downstream logic through a one-entry valid/ready buffer.
- Flags framing and overrun errors, so loopback of the transmitter's "Arglius Barglius\r\n" stream can be checked on-chip.

Parameters:
- CLK_SPEED, 25000000, system clock frequency in Hz.
- BAUD, 115200, line rate.
- CLKS_PER_BIT, CLK_SPEED/BAUD (=217), clocks per bit period.
- HALF_BIT, CLKS_PER_BIT/2 (=108), clocks from start edge to the start-bit mid-sample.

Ports:
- clk  in  1  system clock; only clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- uart_in  in  1  asynchronous serial line; idle high.
- rx_data  out  8  received byte, LSB first on the wire.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky: a byte completed while the buffer was full.
- err_clr  in  1  clears overrun.
- parity_err  out  1  one-cycle pulse; tied 0 when the parity feature is off.

Behaviour:
- Reset values (rst_n=0 at a clk edge): rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0, state=IDLE, counters=0, synchronizer flops=1.
- Reset mid-frame abandons the frame; the partial byte is never delivered.
- uart_in passes through a 2-flop synchronizer. All decisions use the synced value rx_s.
- IDLE: when rx_s=0, clear the bit counter and go to START.
- START: count HALF_BIT clocks, then sample.
  - rx_s=0: go to DATA.
  - rx_s=1 (glitch or false start): return to IDLE; nothing else changes.
- DATA: every CLKS_PER_BIT clocks, sample rx_s into shift register bit [n], n=0..7. After bit 7, go to STOP (or PARITY when that feature is enabled).
- STOP: after CLKS_PER_BIT clocks, sample rx_s.
  - rx_s=1: complete the byte, go to IDLE.
  - rx_s=0: pulse frame_err for 1 cycle, drop the byte, go to RECOVER.
- RECOVER: wait until rx_s=1 for at least one cycle, then go to IDLE. This prevents re-triggering on a break.
- Byte completion (the cycle after the stop sample):
  - Buffer empty, or rx_ready=1 in that same cycle: load rx_data and set rx_valid=1. A simultaneous accept-and-load is not an overrun.
  - Buffer full and rx_ready=0: keep the old rx_data, set overrun=1, discard the new byte.
- Handshake: rx_valid stays high and rx_data stays stable until rx_valid && rx_ready. The next cycle clears rx_valid unless a new byte loads in that same cycle.
- overrun clears only on err_clr=1 or reset. If err_clr and a new overrun occur in the same cycle, overrun stays 1.
- Latency: rx_valid rises 2 sync cycles + HALF_BIT + 9*CLKS_PER_BIT + 1 clocks after the falling edge on uart_in (~9.5 bit times).
- Baud counter width is $clog2(CLKS_PER_BIT+1). It resets to 0 on every sample point and in IDLE. There is no drift correction; the ±2% tolerance comes from mid-bit sampling.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even) and a PARITY state between DATA and STOP.
  - One extra bit period is sampled; the frame is 8E1 or 8O1.
  - On mismatch, parity_err pulses for one cycle, in the cycle the byte completes. The byte is still delivered and follows the normal overrun rules.
  - A framing error takes precedence: no parity_err, no delivery.
- Undefined: 8N1 only; parity_err is constant 0 and there is no PARITY state.

Decomposition:
- Shared package uart_pkg holds:
  - CLK_SPEED, BAUD, CLKS_PER_BIT and HALF_BIT constants, also used by the transmitter.
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP, RECOVER.
- One sub-module: uart_sync2, a 2-flop synchronizer with a reset value of 1, reusable for other async inputs.

Test Plan:
- Send 'A' (0x41) at 217 clk/bit, rx_ready=0 → rx_data=0x41, rx_valid=1 at the computed latency ±1; held stable for 1000 clks; cleared one cycle after a rx_ready pulse.
- Low glitch of 50 clks on idle line → no rx_valid, no frame_err, FSM back in IDLE; a following 0x55 frame is received correctly.
- 0x55 frame with stop bit forced 0, then line high → frame_err exactly one 1-cycle pulse, rx_valid stays 0; next frame 0x0D received.
- 0x0D then 0x0A with rx_ready=0 → rx_data=0x0D, overrun=1; rx_ready pulse delivers 0x0D; err_clr clears overrun; 0x0A is not seen.
- "Arglius Barglius\r\n" (18 bytes) back-to-back, rx_ready=1 → 18 bytes in order, starting 0x41 and ending 0x0D 0x0A, no errors.
- rst_n=0 during bit 4 of 0x73, released → all outputs 0; the next full frame 0x75 is received correctly, with no partial byte delivered.
- With UART_RX_PARITY_EN, even parity:
  - 0x41 with parity bit 0 → delivered, parity_err=0.
  - 0x41 with parity bit 1 → delivered, parity_err pulses for 1 cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the board's UART transmitter and
// receiver.
//   CLK_SPEED, BAUD    : system clock (Hz) and line rate
//   CLKS_PER_BIT       : clocks per bit period (217 at 25 MHz / 115200)
//   HALF_BIT           : clocks from start edge to start-bit mid-sample (108)
//   CNT_W              : width of the baud counter
//   rx_state_t         : receiver FSM states
package uart_pkg;
    localparam int CLK_SPEED    = 25_000_000;
    localparam int BAUD         = 115_200;
    localparam int CLKS_PER_BIT = CLK_SPEED / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        RECOVER
    } rx_state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous level input.
// Resets to 1 so an idle-high line does not look like a start edge.
//   clk   in  : destination clock
//   rst_n in  : synchronous active-low reset
//   d     in  : asynchronous input
//   q     out : synchronized output
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1/8O1 when UART_RX_PARITY_EN is defined)
// with a one-entry valid/ready output buffer.
//   clk        in  : system clock
//   rst_n      in  : synchronous active-low reset
//   uart_in    in  : asynchronous serial line, idle high
//   rx_data    out : received byte
//   rx_valid   out : rx_data holds an unconsumed byte
//   rx_ready   in  : consumer takes the byte when rx_valid && rx_ready
//   frame_err  out : 1-cycle pulse, stop bit sampled low
//   overrun    out : sticky, a byte completed while the buffer was full
//   err_clr    in  : clears overrun
//   parity_err out : 1-cycle pulse on parity mismatch (0 without the feature)
// Optional feature macro: UART_RX_PARITY_EN (adds parameter PARITY_ODD).
module uart_rx
`ifdef UART_RX_PARITY_EN
#(
    parameter bit PARITY_ODD = 1'b0
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       parity_err
);
    import uart_pkg::*;

    logic rx_s;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_in),
        .q     (rx_s)
    );

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;
    logic             done;      // good stop sample: byte completes at this edge
    logic             par_bad;
    logic             new_ovr;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    assign par_bad = ((^shift_q) ^ par_q) != PARITY_ODD;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Bit-timing FSM. The counter restarts at every sample point so each
    // sample lands a whole bit period after the previous one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        done    = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    cnt_d   = '0;
                    // A high line at mid-start is a glitch: drop it quietly.
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RECOVER;
                    end
                end
            end
            RECOVER: begin
                // Hold off until the line returns high so a break
                // cannot be taken as a stream of start bits.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output buffer: an accept in the completion cycle frees the slot, so
    // accept-and-load together is not an overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~rx_ready;
        perr_d  = 1'b0;
        new_ovr = 1'b0;
        if (done) begin
            perr_d = par_bad;
            if (!valid_q || rx_ready) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                new_ovr = 1'b1;
            end
        end
        ovr_d = new_ovr | (ovr_q & ~err_clr);
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign parity_err = perr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. A timeline model predicts when each
// frame completes and what the one-entry buffer must show; a compare process
// checks the outputs every cycle, and literal checks pin key values.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int C = CLKS_PER_BIT;
`ifdef UART_RX_PARITY_EN
    localparam int NB      = 11;
    localparam int LAT_LIT = 2281;
`else
    localparam int NB      = 10;
    localparam int LAT_LIT = 2064;
`endif
    // falling edge to rx_valid: 2 sync + half bit + remaining bits to stop + 1
    localparam int LAT = 2 + HALF_BIT + (NB - 1) * C + 1;

    logic       clk = 1'b0;
    logic       rst_n, uart_in, rx_ready, err_clr;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, parity_err;

    uart_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_in    (uart_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr),
        .parity_err (parity_err)
    );

    always #20 clk = ~clk;

    typedef struct {
        int       at;
        logic [7:0] b;
        bit       ferr;
        bit       perr;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 0;
    logic       m_valid = 0, m_ferr = 0, m_ovr = 0, m_perr = 0;
    logic [7:0] m_data = 0;
    logic [7:0] got[$];
    int         rise_cyc = 0, ferr_cnt = 0, perr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: frames become completion events at known cycles; the buffer
    // follows the valid/ready and overrun rules.
    initial forever begin
        ev_t e;
        bit  newov;
        @(posedge clk);
        cyc++;
        m_ferr = 0;
        m_perr = 0;
        if (!rst_n) begin
            m_valid = 0; m_ovr = 0; m_data = 0;
            evq.delete();
        end else begin
            newov = 0;
            if (m_valid && rx_ready) m_valid = 0;
            if (evq.size() > 0 && evq[0].at == cyc) begin
                e = evq.pop_front();
                if (e.ferr) m_ferr = 1;
                else begin
                    m_perr = e.perr;
                    if (!m_valid) begin m_valid = 1; m_data = e.b; end
                    else newov = 1;
                end
            end
            m_ovr = newov | (m_ovr & ~err_clr);
        end
    end

    // Compare process.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("rx_valid", 32'(rx_valid), 32'(m_valid));
            check("frame_err", 32'(frame_err), 32'(m_ferr));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("parity_err", 32'(parity_err), 32'(m_perr));
            if (m_valid) check("rx_data", 32'(rx_data), 32'(m_data));
        end
    end

    // Monitor: handshakes, first rise of rx_valid, error pulse counts.
    initial begin
        logic prev_v;
        prev_v = 0;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1 && rx_ready) got.push_back(rx_data);
            if (rx_valid === 1'b1 && !prev_v) rise_cyc = cyc;
            if (frame_err === 1'b1) ferr_cnt++;
            if (parity_err === 1'b1) perr_cnt++;
            prev_v = (rx_valid === 1'b1);
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got cycle %0d expected finish earlier", cyc);
        $fatal(1, "timeout");
    end

    // Drive one frame from a negedge; abort_bit >= 0 resets mid data bit.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit,
                              input bit par_flip, input int abort_bit);
        logic [NB-1:0] fr;
        ev_t e;
        fr[0]   = 1'b0;
        fr[8:1] = b;
`ifdef UART_RX_PARITY_EN
        fr[9]   = (^b) ^ par_flip;   // even parity unless flipped
`endif
        fr[NB-1] = stop_bit;
        e.at = cyc + LAT; e.b = b; e.ferr = !stop_bit; e.perr = par_flip;
        evq.push_back(e);
        for (int i = 0; i < NB; i++) begin
            uart_in = fr[i];
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                repeat (C / 2) @(negedge clk);
                rst_n = 0; uart_in = 1;
                repeat (4) @(negedge clk);
                rst_n = 1;
                return;
            end
            repeat (C) @(negedge clk);
        end
    endtask

    task automatic pulse_ready();
        rx_ready = 1;
        @(negedge clk);
        rx_ready = 0;
    endtask

    initial begin
        int   t0;
        string msg;
        logic [7:0] bytes[$];

        rst_n = 0; uart_in = 1; rx_ready = 0; err_clr = 0;
        repeat (5) @(negedge clk);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_parity_err", 32'(parity_err), 0);
        chk_en = 1;
        rst_n = 1;
        repeat (3) @(negedge clk);

        // 'A', held 1000 clocks without ready
        t0 = cyc;
        send_frame(8'h41, 1, 0, -1);
        repeat (1000) @(negedge clk);
        check("lat_A_window", 32'((rise_cyc - t0 >= LAT_LIT - 1) && (rise_cyc - t0 <= LAT_LIT + 1)), 1);
        check("A_data", 32'(rx_data), 32'h41);
        check("A_valid", 32'(rx_valid), 1);
        pulse_ready();
        check("A_cleared", 32'(rx_valid), 0);

        // glitch then 0x55
        uart_in = 0;
        repeat (50) @(negedge clk);
        uart_in = 1;
        repeat (200) @(negedge clk);
        check("glitch_idle", 32'(dut.state_q), 32'(IDLE));
        check("glitch_valid", 32'(rx_valid), 0);
        send_frame(8'h55, 1, 0, -1);
        repeat (20) @(negedge clk);
        check("55_data", 32'(rx_data), 32'h55);
        pulse_ready();

        // framing error, then 0x0D
        ferr_cnt = 0;
        send_frame(8'h55, 0, 0, -1);
        uart_in = 1;
        repeat (50) @(negedge clk);
        check("ferr_pulses", 32'(ferr_cnt), 1);
        check("ferr_no_valid", 32'(rx_valid), 0);
        send_frame(8'h0D, 1, 0, -1);
        repeat (20) @(negedge clk);
        check("0D_after_ferr", 32'(rx_data), 32'h0D);
        pulse_ready();

        // overrun: 0x0D kept, 0x0A dropped
        send_frame(8'h0D, 1, 0, -1);
        send_frame(8'h0A, 1, 0, -1);
        repeat (20) @(negedge clk);
        check("ovr_set", 32'(overrun), 1);
        check("ovr_data", 32'(rx_data), 32'h0D);
        pulse_ready();
        check("ovr_drop", 32'(rx_valid), 0);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        check("ovr_clr", 32'(overrun), 0);

        // message stream with ready held high
        msg = "Arglius Barglius";
        for (int i = 0; i < msg.len(); i++) bytes.push_back(msg[i]);
        bytes.push_back(8'h0D);
        bytes.push_back(8'h0A);
        got.delete();
        rx_ready = 1;
        foreach (bytes[i]) send_frame(bytes[i], 1, 0, -1);
        repeat (20) @(negedge clk);
        check("msg_count", 32'(got.size()), 18);
        if (got.size() == 18) begin
            check("msg_first", 32'(got[0]), 32'h41);
            check("msg_cr", 32'(got[16]), 32'h0D);
            check("msg_lf", 32'(got[17]), 32'h0A);
        end
        check("msg_ovr", 32'(overrun), 0);
        rx_ready = 0;

        // reset during bit 4 of 0x73, then 0x75
        send_frame(8'h73, 1, 0, 4);
        check("abort_valid", 32'(rx_valid), 0);
        check("abort_data", 32'(rx_data), 0);
        check("abort_ovr", 32'(overrun), 0);
        check("abort_ferr", 32'(frame_err), 0);
        repeat (5) @(negedge clk);
        send_frame(8'h75, 1, 0, -1);
        repeat (20) @(negedge clk);
        check("75_data", 32'(rx_data), 32'h75);
        check("75_valid", 32'(rx_valid), 1);
        pulse_ready();

`ifdef UART_RX_PARITY_EN
        perr_cnt = 0;
        send_frame(8'h41, 1, 0, -1);
        repeat (20) @(negedge clk);
        check("par_ok_data", 32'(rx_data), 32'h41);
        check("par_ok_pulses", 32'(perr_cnt), 0);
        pulse_ready();
        send_frame(8'h41, 1, 1, -1);
        repeat (20) @(negedge clk);
        check("par_bad_data", 32'(rx_data), 32'h41);
        check("par_bad_pulses", 32'(perr_cnt), 1);
        pulse_ready();
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
